// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the APB master and the apb_slave_mem completer.
// The master modport drives the request side. The slave modport drives the response side.
interface apb_slave_mem_if #(
   parameter int ADDR = 5,
   parameter int DATA = 32
);
   logic            psel;
   logic            penable;
   logic            pwrite;
   logic [ADDR-1:0] paddr;
   logic [DATA-1:0] pwdata;
   logic [DATA-1:0] prdata;
   logic            preadyout;
   logic            pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, preadyout, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, preadyout, pslverr
   );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: an APB completer that holds a word-addressed register memory.
// Each transfer is a setup phase followed by access cycles. Transfers are answered with a
// registered preadyout, read data and an error flag.
// Addresses at or above DEPTH report pslverr. Writes to those addresses are dropped,
// and reads from them return 0.
// Optional feature: when APB_SLV_WAIT_EN is defined, WAIT wait cycles are inserted into
// every transfer. When it is undefined, every transfer completes in the first access cycle.
module apb_slave_mem #(
   parameter int ADDR  = 5,
   parameter int DATA  = 32,
   parameter int DEPTH = 24,
   parameter int WAIT  = 2
) (
   input logic           pclk,
   input logic           prst,
   apb_slave_mem_if.slave bus
);

   // Catch configurations the memory and the wait counter cannot represent.
   if (DEPTH < 1 || DEPTH > (1 << ADDR)) begin : g_bad_depth
      $error("apb_slave_mem: DEPTH must be in 1..2**ADDR");
   end
   if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
      $error("apb_slave_mem: WAIT must be in 0..15");
   end

`ifdef APB_SLV_WAIT_EN
   localparam int EFF_WAIT = WAIT;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;
`else
   typedef enum logic {ST_IDLE, ST_READY} state_t;
`endif

   localparam logic [ADDR:0] DEPTH_W = DEPTH[ADDR:0];

   state_t          state, state_n;
`ifdef APB_SLV_WAIT_EN
   logic [3:0]      cnt, cnt_n;
`endif

   // Transfer context, captured at the setup phase.
   logic [ADDR-1:0] addr_q;
   logic            wr_q;
   logic            err_q;
   logic [DATA-1:0] wdata_q;

   logic [DATA-1:0] prdata_q;
   logic            ready_q;
   logic            err_out_q;

   logic [DATA-1:0] mem [DEPTH];

   logic            setup;
   logic            start;
   logic            latch;
   logic            load;
   logic            commit;
   logic [ADDR-1:0] cur_addr;
   logic            cur_wr;
   logic            cur_err;
   logic [DATA-1:0] rd_word;

   assign setup = bus.psel & ~bus.penable;

   // Next-state logic, and the strobes that capture the transfer, load the outputs and commit writes.
   always_comb begin
      state_n = state;
`ifdef APB_SLV_WAIT_EN
      cnt_n   = cnt;
`endif
      start   = 1'b0;
      latch   = 1'b0;
      load    = 1'b0;
      commit  = 1'b0;
      case (state)
         ST_IDLE: begin
            // When psel and penable are both high here, it is a protocol violation. It falls through and is ignored.
            if (setup) start = 1'b1;
         end
`ifdef APB_SLV_WAIT_EN
         ST_WAIT: begin
            if (!bus.psel) begin
               state_n = ST_IDLE;
            end else if (bus.penable) begin
               if (cnt == 4'd0) begin
                  state_n = ST_READY;
                  load    = 1'b1;
               end else begin
                  cnt_n = cnt - 4'd1;
               end
            end
         end
`endif
         ST_READY: begin
            commit  = wr_q & ~err_q;
            state_n = ST_IDLE;
            if (setup) start = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase

      if (start) begin
         latch = 1'b1;
`ifdef APB_SLV_WAIT_EN
         if (EFF_WAIT == 0) begin
            state_n = ST_READY;
            load    = 1'b1;
         end else begin
            state_n = ST_WAIT;
            cnt_n   = 4'(EFF_WAIT - 1);
         end
`else
         state_n = ST_READY;
         load    = 1'b1;
`endif
      end
   end

   // Zero-wait transfers load their outputs on the setup edge itself, so they use the live bus values.
   always_comb begin
      cur_addr = latch ? bus.paddr  : addr_q;
      cur_wr   = latch ? bus.pwrite : wr_q;
      cur_err  = ({1'b0, cur_addr} >= DEPTH_W);
      rd_word  = '0;
      if (!cur_err) begin
         // Forward a write that commits on this same edge, so a back-to-back read does not see stale data.
         if (commit && (addr_q == cur_addr)) rd_word = wdata_q;
         else                                rd_word = mem[cur_addr];
      end
   end

   // State, wait counter and transfer context registers.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state   <= ST_IDLE;
`ifdef APB_SLV_WAIT_EN
         cnt     <= 4'd0;
`endif
         addr_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         state <= state_n;
`ifdef APB_SLV_WAIT_EN
         cnt   <= cnt_n;
`endif
         if (latch) begin
            addr_q  <= bus.paddr;
            wr_q    <= bus.pwrite;
            err_q   <= cur_err;
            wdata_q <= bus.pwdata;
         end
      end
   end

   // Registered response. preadyout is a one-cycle pulse. prdata changes only on reads.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         ready_q   <= 1'b0;
         err_out_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         ready_q   <= load;
         err_out_q <= load & cur_err;
         if (load && !cur_wr) prdata_q <= rd_word;
      end
   end

   // Memory array. A write commits at the closing edge of READY, and only when the address was in range.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (commit) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign bus.prdata    = prdata_q;
   assign bus.preadyout = ready_q;
   assign bus.pslverr   = err_out_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem.
// A transaction-level model (memory array plus expected response) is compared on every negedge.
// Literal checks pin the model at key points.
module tb_apb_slave_mem;
   localparam int ADDR  = 5;
   localparam int DATA  = 32;
   localparam int DEPTH = 24;
   localparam int WAIT  = 3;
`ifdef APB_SLV_WAIT_EN
   localparam int N = WAIT;
`else
   localparam int N = 0;
`endif

   logic pclk = 1'b0;
   logic prst = 1'b1;

   apb_slave_mem_if #(.ADDR(ADDR), .DATA(DATA)) bus ();

   apb_slave_mem #(.ADDR(ADDR), .DATA(DATA), .DEPTH(DEPTH), .WAIT(WAIT)) dut (
      .pclk (pclk),
      .prst (prst),
      .bus  (bus)
   );

   always #5 pclk = ~pclk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   // Transaction-level model.
   logic [31:0] model_mem [32];
   logic [31:0] exp_rdata;
   logic        exp_ready;
   logic        exp_err;
   logic        chk_on = 1'b0;

   logic [31:0] got_rdata;
   logic        got_ready;
   logic        got_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = '0;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge pclk) begin
      if (chk_on) begin
         check("cyc_preadyout", 32'(bus.preadyout), 32'(exp_ready));
         check("cyc_pslverr",   32'(bus.pslverr),   32'(exp_err));
         check("cyc_prdata",    bus.prdata,         exp_rdata);
      end
   end

   task automatic idle(input int n);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // One full transfer: a setup cycle, then N access cycles not yet ready, then the ready access cycle.
   task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic keep);
      logic err;
      err         = (int'(a) >= DEPTH);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = wr;
      bus.paddr   = a;
      bus.pwdata  = d;
      @(posedge pclk);
      #1;
      bus.penable = 1'b1;
      for (int i = 0; i < N; i++) begin
         @(posedge pclk);
         #1;
      end
      exp_ready = 1'b1;
      exp_err   = err;
      if (!wr) exp_rdata = err ? 32'h0 : model_mem[a];
      #3;
      got_ready = bus.preadyout;
      got_err   = bus.pslverr;
      got_rdata = bus.prdata;
      @(posedge pclk);
      #1;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      if (wr && !err) model_mem[a] = d;
      if (!keep) begin
         bus.psel    = 1'b0;
         bus.penable = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = '0;
      bus.pwdata  = '0;
      model_reset();
      prst = 1'b1;
      #1;
      chk_on = 1'b1;
      #1;
      check("rst_preadyout", 32'(bus.preadyout), 32'h0);
      check("rst_pslverr",   32'(bus.pslverr),   32'h0);
      check("rst_prdata",    bus.prdata,         32'h0);
      @(posedge pclk);
      #1;
      prst = 1'b0;
      idle(2);

      // Read after reset.
      xfer(1'b0, 5'd3, 32'h0, 1'b0);
      check("rd3_ready", 32'(got_ready), 32'h1);
      check("rd3_err",   32'(got_err),   32'h0);
      check("rd3_data",  got_rdata,      32'h0);
      idle(1);

      // Write, then read back.
      xfer(1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
      check("wr7_ready", 32'(got_ready), 32'h1);
      check("model_mem7", model_mem[7], 32'hDEADBEEF);
      idle(1);
      xfer(1'b0, 5'd7, 32'h0, 1'b0);
      check("rd7_data", got_rdata,      32'hDEADBEEF);
      check("rd7_err",  32'(got_err),   32'h0);
      idle(1);

      // Out-of-range address.
      xfer(1'b1, 5'd30, 32'h12345678, 1'b0);
      check("wr30_err", 32'(got_err), 32'h1);
      idle(1);
      xfer(1'b0, 5'd30, 32'h0, 1'b0);
      check("rd30_data", got_rdata,    32'h0);
      check("rd30_err",  32'(got_err), 32'h1);
      idle(1);
      xfer(1'b0, 5'd6, 32'h0, 1'b0);
      check("rd6_data", got_rdata,    32'h0);
      check("rd6_err",  32'(got_err), 32'h0);
      idle(1);

      // Back-to-back transfers with psel held high.
      t0 = cyc;
      xfer(1'b1, 5'd1, 32'hA, 1'b1);
      xfer(1'b1, 5'd2, 32'hB, 1'b1);
      xfer(1'b0, 5'd1, 32'h0, 1'b1);
      check("b2b_rd1", got_rdata, 32'hA);
      xfer(1'b0, 5'd2, 32'h0, 1'b0);
      check("b2b_rd2", got_rdata, 32'hB);
      check("b2b_cycles", 32'(cyc - t0), 32'(4 * (2 + N)));
      idle(1);

      // Protocol violation: psel and penable both high in IDLE are ignored.
      bus.psel    = 1'b1;
      bus.penable = 1'b1;
      bus.pwrite  = 1'b1;
      bus.paddr   = 5'd9;
      bus.pwdata  = 32'h99;
      repeat (3) begin
         @(posedge pclk);
         #1;
      end
      idle(2);
      xfer(1'b0, 5'd9, 32'h0, 1'b0);
      check("viol_rd9", got_rdata, 32'h0);
      idle(1);

`ifdef APB_SLV_WAIT_EN
      // Abort: drop psel in the second wait cycle of a write.
      xfer(1'b1, 5'd4, 32'h44, 1'b0);
      idle(1);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b1;
      bus.paddr   = 5'd4;
      bus.pwdata  = 32'hBAD;
      @(posedge pclk);
      #1;
      bus.penable = 1'b1;
      @(posedge pclk);
      #1;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      idle(4);
      xfer(1'b0, 5'd4, 32'h0, 1'b0);
      check("abort_rd4", got_rdata, 32'h44);
      idle(1);
`endif

      // Reset in the first access cycle of a write.
      xfer(1'b0, 5'd7, 32'h0, 1'b0);
      check("pre_rst_rd7", got_rdata, 32'hDEADBEEF);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b1;
      bus.paddr   = 5'd5;
      bus.pwdata  = 32'h55;
      @(posedge pclk);
      #1;
      bus.penable = 1'b1;
      #1;
      prst = 1'b1;
      model_reset();
      #1;
      check("midrst_preadyout", 32'(bus.preadyout), 32'h0);
      check("midrst_pslverr",   32'(bus.pslverr),   32'h0);
      check("midrst_prdata",    bus.prdata,         32'h0);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      @(posedge pclk);
      @(posedge pclk);
      #1;
      prst = 1'b0;
      idle(1);
      xfer(1'b0, 5'd5, 32'h0, 1'b0);
      check("post_rst_rd5", got_rdata, 32'h0);
      xfer(1'b0, 5'd7, 32'h0, 1'b0);
      check("post_rst_rd7", got_rdata, 32'h0);
      idle(2);

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
